multi_player_score_tracker: RTL and testbench

//  Parametrised successor to the single-score counter: keeps one score per player,

---
 rtl/multi_player_score_tracker_pkg.sv | 21 ++
 rtl/multi_player_score_tracker_if.sv | 34 +++
 rtl/multi_player_score_tracker_score_cell.sv | 35 +++
 rtl/multi_player_score_tracker.sv | 135 +++++++++++++
 tb/tb_multi_player_score_tracker.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/multi_player_score_tracker_pkg.sv
// Purpose: shared types and constants for the multi-player score tracker.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AIM  = 2'd1,
        ST_ROLL = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    localparam int SCORE_W_DEF = 4;
    localparam int MAX_PLAYERS = 8;

    // Player index width; one bit minimum so a 2-player build still has a port.
    function automatic int playerWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multi_player_score_tracker_if.sv
// Purpose: event pulses in, scores/turn/winner out, for the score tracker.
// Latency: n/a (signal bundle only).
// Backpressure: none; every pulse is sampled on the cycle it is high.
interface multi_player_score_tracker_if
    import score_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_W     = SCORE_W_DEF
) ();
    localparam int PW = playerWidth(NUM_PLAYERS);

    logic                                  startGame;
    logic                                  shotFired;
    logic                                  ballsStopped;
    logic                                  increaseScore;
    logic                                  decreaseScore;
    logic [PW-1:0]                         currentPlayer;
    logic [NUM_PLAYERS-1:0][SCORE_W-1:0]   scores;
    logic                                  turnChanged;
    logic                                  gameOver;
    logic [PW-1:0]                         winner;

    // Game-event source (collision logic / bench).
    modport master (
        output startGame, shotFired, ballsStopped, increaseScore, decreaseScore,
        input  currentPlayer, scores, turnChanged, gameOver, winner
    );

    // Tracker side.
    modport slave (
        input  startGame, shotFired, ballsStopped, increaseScore, decreaseScore,
        output currentPlayer, scores, turnChanged, gameOver, winner
    );
endinterface

// File: rtl/multi_player_score_tracker_score_cell.sv
// Purpose: one player's saturating up/down score counter with synchronous clear.
// Latency: 1 cycle from clear/inc/dec to score; scoreNext is the combinational look-ahead.
// Backpressure: none; inc/dec accepted every cycle.
module score_cell #(
    parameter int SCORE_W = 4
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               clear,
    input  logic               inc,
    input  logic               dec,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] scoreNext
);
    localparam logic [SCORE_W-1:0] MAX_SCORE = '1;

    // Next value: clear wins, inc+dec together cancel, saturate at both ends.
    always_comb begin
        scoreNext = score;
        if (clear)
            scoreNext = '0;
        else if (inc && !dec && score != MAX_SCORE)
            scoreNext = score + SCORE_W'(1);
        else if (dec && !inc && score != '0)
            scoreNext = score - SCORE_W'(1);
    end

    // Score register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            score <= '0;
        else
            score <= scoreNext;
    end
endmodule

// File: rtl/multi_player_score_tracker.sv
// Purpose: per-player scores, turn rotation and winner detection; FOUL_PENALTY_EN gives the next player a point on a foul.
// Latency: 1 cycle from any event pulse to the registered outputs.
// Backpressure: none; pulses in the wrong state are dropped, startGame always wins.
module multi_player_score_tracker
    import score_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int SCORE_W      = SCORE_W_DEF,
    parameter int TARGET_SCORE = 7
) (
    input  logic                          clk,
    input  logic                          resetN,
    multi_player_score_tracker_if.slave   bus
);
    localparam int PW = playerWidth(NUM_PLAYERS);
    localparam logic [SCORE_W-1:0] TARGET   = SCORE_W'(TARGET_SCORE);
    localparam logic [PW-1:0]      LAST_IDX = PW'(NUM_PLAYERS - 1);

    state_t                              state;
    logic [PW-1:0]                       curPlayer;
    logic [PW-1:0]                       nextPlayer;
    logic [PW-1:0]                       winIdx;
    logic                                hasWin;
    logic                                potted;
    logic                                foul;
    logic                                pottedNow;
    logic                                foulNow;
    logic                                inRoll;
    logic [NUM_PLAYERS-1:0]              incVec;
    logic [NUM_PLAYERS-1:0]              decVec;
    logic [NUM_PLAYERS-1:0][SCORE_W-1:0] scoreVec;
    logic [NUM_PLAYERS-1:0][SCORE_W-1:0] nextScores;

    assign inRoll     = (state == ST_ROLL);
    assign nextPlayer = (curPlayer == LAST_IDX) ? '0 : curPlayer + PW'(1);
    // Flags including this cycle's pulses, so an event coincident with
    // ballsStopped counts toward the end-of-shot decision.
    assign pottedNow  = potted | bus.increaseScore;
    assign foulNow    = foul   | bus.decreaseScore;

    // Route score events to the shooter's counter (and the foul penalty, if built in).
    always_comb begin
        incVec = '0;
        decVec = '0;
        if (inRoll) begin
            incVec[curPlayer] = bus.increaseScore;
            decVec[curPlayer] = bus.decreaseScore;
`ifdef FOUL_PENALTY_EN
            if (bus.ballsStopped && foulNow)
                incVec[nextPlayer] = 1'b1;
`endif
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_PLAYERS; g++) begin : gen_cell
            score_cell #(.SCORE_W(SCORE_W)) u_cell (
                .clk       (clk),
                .resetN    (resetN),
                .clear     (bus.startGame),
                .inc       (incVec[g]),
                .dec       (decVec[g]),
                .score     (scoreVec[g]),
                .scoreNext (nextScores[g])
            );
        end
    endgenerate

    // Lowest-indexed player whose post-event score reaches the target.
    always_comb begin
        hasWin = 1'b0;
        winIdx = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (nextScores[i] >= TARGET) begin
                hasWin = 1'b1;
                winIdx = PW'(i);
            end
        end
    end

    // Game FSM with registered turn/winner outputs and per-shot flags.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= ST_IDLE;
            curPlayer   <= '0;
            bus.winner  <= '0;
            bus.turnChanged <= 1'b0;
            bus.gameOver    <= 1'b0;
            potted      <= 1'b0;
            foul        <= 1'b0;
        end else begin
            bus.turnChanged <= 1'b0;
            if (bus.startGame) begin
                state        <= ST_AIM;
                curPlayer    <= '0;
                bus.winner   <= '0;
                bus.gameOver <= 1'b0;
                potted       <= 1'b0;
                foul         <= 1'b0;
            end else begin
                case (state)
                    ST_AIM: begin
                        if (bus.shotFired) begin
                            state  <= ST_ROLL;
                            potted <= 1'b0;
                            foul   <= 1'b0;
                        end
                    end
                    ST_ROLL: begin
                        potted <= pottedNow;
                        foul   <= foulNow;
                        if (bus.ballsStopped) begin
                            if (hasWin) begin
                                state        <= ST_OVER;
                                bus.gameOver <= 1'b1;
                                bus.winner   <= winIdx;
                            end else begin
                                state <= ST_AIM;
                                if (foulNow || !pottedNow) begin
                                    curPlayer       <= nextPlayer;
                                    bus.turnChanged <= 1'b1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.currentPlayer = curPlayer;
    assign bus.scores        = scoreVec;
endmodule

// File: tb/tb_multi_player_score_tracker.sv
// Purpose: directed checks of the score tracker with three players, 4-bit scores, target 7.
// Latency: outputs checked on the falling edge after the capturing rising edge.
// Backpressure: n/a.
module tb_multi_player_score_tracker;
    import score_pkg::*;

    localparam int NP = 3;
    localparam int SW = 4;

    logic clk;
    logic resetN;
    int   total;
    int   passed;

`ifdef FOUL_PENALTY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif

    multi_player_score_tracker_if #(.NUM_PLAYERS(NP), .SCORE_W(SW)) bus ();

    multi_player_score_tracker #(
        .NUM_PLAYERS  (NP),
        .SCORE_W      (SW),
        .TARGET_SCORE (7)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One-cycle pulse of the selected inputs; returns on the falling edge after capture.
    task automatic pulse(input logic st, input logic sh, input logic bs,
                         input logic inc, input logic dec);
        @(negedge clk);
        bus.startGame     = st;
        bus.shotFired     = sh;
        bus.ballsStopped  = bs;
        bus.increaseScore = inc;
        bus.decreaseScore = dec;
        @(negedge clk);
        bus.startGame     = 1'b0;
        bus.shotFired     = 1'b0;
        bus.ballsStopped  = 1'b0;
        bus.increaseScore = 1'b0;
        bus.decreaseScore = 1'b0;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        resetN = 1'b0;
        bus.startGame     = 1'b0;
        bus.shotFired     = 1'b0;
        bus.ballsStopped  = 1'b0;
        bus.increaseScore = 1'b0;
        bus.decreaseScore = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_scores",   32'(bus.scores), 0);
        check("rst_player",   32'(bus.currentPlayer), 0);
        check("rst_winner",   32'(bus.winner), 0);
        check("rst_turnchg",  32'(bus.turnChanged), 0);
        check("rst_gameover", 32'(bus.gameOver), 0);
        check("rst_state",    32'(dut.state), 32'(ST_IDLE));

        resetN = 1'b1;
        // Mid-shot reset, then restart.
        pulse(1, 0, 0, 0, 0);
        pulse(0, 1, 0, 0, 0);
        pulse(0, 0, 0, 1, 0);
        check("midshot_s0", 32'(bus.scores[0]), 1);
        @(negedge clk);
        resetN = 1'b0;
        #1;
        check("async_rst_s0",    32'(bus.scores[0]), 0);
        check("async_rst_state", 32'(dut.state), 32'(ST_IDLE));
        @(negedge clk);
        resetN = 1'b1;
        pulse(1, 0, 0, 0, 0);
        check("restart_scores", 32'(bus.scores), 0);
        check("restart_player", 32'(bus.currentPlayer), 0);
        check("restart_over",   32'(bus.gameOver), 0);
        check("restart_state",  32'(dut.state), 32'(ST_AIM));

        // P0 pots twice: keeps the turn.
        pulse(0, 1, 0, 0, 0);
        pulse(0, 0, 0, 1, 0);
        pulse(0, 0, 0, 1, 0);
        pulse(0, 0, 1, 0, 0);
        check("pot2_s0",     32'(bus.scores[0]), 2);
        check("pot2_player", 32'(bus.currentPlayer), 0);
        check("pot2_turnchg", 32'(bus.turnChanged), 0);
        check("pot2_state",  32'(dut.state), 32'(ST_AIM));

        // P0 misses: turn to P1, single-cycle pulse.
        pulse(0, 1, 0, 0, 0);
        pulse(0, 0, 1, 0, 0);
        check("miss_player",  32'(bus.currentPlayer), 1);
        check("miss_tc_high", 32'(bus.turnChanged), 1);
        @(negedge clk);
        check("miss_tc_low",  32'(bus.turnChanged), 0);

        // P1 fouls at 0: floors at 0, turn to P2.
        pulse(0, 1, 0, 0, 0);
        pulse(0, 0, 0, 0, 1);
        pulse(0, 0, 1, 0, 0);
        check("floor_s1",     32'(bus.scores[1]), 0);
        check("foul_player",  32'(bus.currentPlayer), 2);
        check("foul_tc",      32'(bus.turnChanged), 1);

        // P2 misses: wraps to P0.
        pulse(0, 1, 0, 0, 0);
        pulse(0, 0, 1, 0, 0);
        check("wrap_player",  32'(bus.currentPlayer), 0);
        check("wrap_tc",      32'(bus.turnChanged), 1);

        // Events in ST_AIM are ignored.
        pulse(0, 0, 1, 0, 0);
        check("aim_stop_player", 32'(bus.currentPlayer), 0);
        check("aim_stop_tc",     32'(bus.turnChanged), 0);
        pulse(0, 0, 0, 1, 0);
        check("aim_inc_s0",      32'(bus.scores[0]), 2);

        // P0 to 3, then foul: P0=2, penalty point to P1 if enabled.
        pulse(0, 1, 0, 0, 0);
        pulse(0, 0, 0, 1, 0);
        pulse(0, 0, 1, 0, 0);
        check("to3_s0", 32'(bus.scores[0]), 3);
        pulse(0, 1, 0, 0, 0);
        pulse(0, 0, 0, 0, 1);
        pulse(0, 0, 1, 0, 0);
        check("foul3_s0",     32'(bus.scores[0]), 2);
        check("foul3_s1",     32'(bus.scores[1]), PEN);
        check("foul3_player", 32'(bus.currentPlayer), 1);

        // P1: inc+dec together cancels, then saturates at 15, then wins.
        pulse(0, 1, 0, 0, 0);
        pulse(0, 0, 0, 1, 1);
        check("incdec_s1", 32'(bus.scores[1]), PEN);
        for (int i = 0; i < 16; i++) pulse(0, 0, 0, 1, 0);
        check("sat_s1", 32'(bus.scores[1]), 15);
        pulse(0, 0, 1, 0, 0);
        check("win_over",    32'(bus.gameOver), 1);
        check("win_winner",  32'(bus.winner), 1);
        check("win_player",  32'(bus.currentPlayer), 1);
        check("win_tc",      32'(bus.turnChanged), 0);
        check("win_state",   32'(dut.state), 32'(ST_OVER));

        // Events after game over are ignored.
        pulse(0, 1, 0, 0, 0);
        pulse(0, 0, 0, 1, 0);
        pulse(0, 0, 0, 0, 1);
        pulse(0, 0, 1, 0, 0);
        check("over_s0",     32'(bus.scores[0]), 2);
        check("over_s1",     32'(bus.scores[1]), 15);
        check("over_hold",   32'(bus.gameOver), 1);
        check("over_winner", 32'(bus.winner), 1);

        // New game from ST_OVER.
        pulse(1, 0, 0, 0, 0);
        check("new_over",   32'(bus.gameOver), 0);
        check("new_scores", 32'(bus.scores), 0);
        check("new_player", 32'(bus.currentPlayer), 0);
        check("new_state",  32'(dut.state), 32'(ST_AIM));

        // Target boundary: 6 does not win, exactly 7 does.
        pulse(0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) pulse(0, 0, 0, 1, 0);
        pulse(0, 0, 1, 0, 0);
        check("six_over",   32'(bus.gameOver), 0);
        check("six_player", 32'(bus.currentPlayer), 0);
        pulse(0, 1, 0, 0, 0);
        pulse(0, 0, 1, 1, 0);
        check("seven_s0",     32'(bus.scores[0]), 7);
        check("seven_over",   32'(bus.gameOver), 1);
        check("seven_winner", 32'(bus.winner), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
